piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_pkg.sv | 25 ++
 rtl/piso_bit_counter.sv | 42 ++++
 rtl/piso_serializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// piso_pkg -- shared definitions for the PISO serializer.
//
// Holds the FSM state encoding used by piso_serializer, the state-register
// width and a small parity helper. State constants are plain localparams so
// legacy code that compares raw state codes keeps working.
//
// The PARITY code is always defined here; whether any logic reaches it is
// decided in piso_serializer by PISO_SERIALIZER_PARITY_EN.

package piso_pkg;

  // State register width and encodings.
  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] SHIFT  = 2'd1;
  localparam logic [STATE_W-1:0] PARITY = 2'd2;

  // Even parity over a zero-extended word: 1 when the word has an odd number
  // of ones, so that word plus parity bit always carries an even count.
  function automatic logic even_parity(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter -- bit index counter for the PISO serializer.
//
// Counts 0..WIDTH-1 and wraps back to 0 on the cycle after terminal count.
// Clear takes priority over enable, so a word accepted on the terminal-count
// cycle restarts the index at 0 for the next frame.
//
// Parameters:
//   WIDTH   number of bits per word (2..32); counter is $clog2(WIDTH) wide
// Ports:
//   clk     clock, rising edge
//   reset   synchronous, active-low
//   clear   force count to 0 (priority over enable)
//   enable  advance count by one
//   tc      high while count == WIDTH-1

module piso_bit_counter #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      // Explicit wrap so non-power-of-two widths stay within 0..WIDTH-1.
      count <= tc ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer -- parallel-in / serial-out word serializer.
//
// Accepts a WIDTH-bit word on a valid/ready handshake and emits it one bit
// per cycle on out_bit, starting the cycle after acceptance. A new word may be
// accepted in the last-bit cycle of the current frame, giving a gap-free
// stream. frame_end marks the final bit of every frame.
//
// Build option:
//   PISO_SERIALIZER_PARITY_EN  when defined, each frame gets one extra
//                              even-parity bit (XOR of the data bits) emitted
//                              in state PARITY right after the data bits.
//
// Parameters:
//   WIDTH      parallel word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-low
//   load_valid  load_data holds a word to serialize
//   load_data   parallel word
//   load_ready  a word can be accepted this cycle
//   out_bit     serial data (registered)
//   out_valid   out_bit is a live stream bit
//   frame_end   high with the final bit of each frame

module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_end
);

  // State reflects what is currently on out_bit: SHIFT means a data bit,
  // PARITY the parity bit, IDLE nothing.
  logic [STATE_W-1:0] state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic               bit_q, bit_d;
  logic               vld_q, vld_d;
  // Low from a reset edge until the first edge with reset released, so
  // load_ready stays low throughout reset.
  logic               run_q;

  logic cnt_clr, cnt_en, cnt_tc;
  logic accept, last_bit, first_bit, next_bit;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q;
`endif

  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  // The counter tracks the index of the bit currently on out_bit, so the
  // last data bit is the cycle where it sits at terminal count.
`ifdef PISO_SERIALIZER_PARITY_EN
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && cnt_tc;
`endif

  assign load_ready = run_q && ((state_q == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign out_bit    = bit_q;
  assign out_valid  = vld_q;
  assign frame_end  = last_bit;

  // First bit comes straight from load_data so it can be registered on the
  // acceptance edge. Afterwards the register is shifted so that the bit on
  // out_bit always sits at the leading end; the next bit is its neighbour.
  assign first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit  = MSB_FIRST ? sh_q[WIDTH-2]      : sh_q[1];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = 1'b0;
    vld_d   = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;

    if (accept) begin
      // Also covers a load in the last-bit cycle: next frame starts at once.
      state_d = SHIFT;
      sh_d    = load_data;
      bit_d   = first_bit;
      vld_d   = 1'b1;
      cnt_clr = 1'b1;
    end else if ((state_q == SHIFT) && !cnt_tc) begin
      sh_d    = MSB_FIRST ? (sh_q << 1) : (sh_q >> 1);
      bit_d   = next_bit;
      vld_d   = 1'b1;
      cnt_en  = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
    end else if ((state_q == SHIFT) && cnt_tc) begin
      state_d = PARITY;
      bit_d   = par_q;
      vld_d   = 1'b1;
`endif
    end else begin
      // Idle, or the last bit went out with no follow-on load.
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
      run_q   <= 1'b1;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  // Parity is computed once from the accepted word rather than accumulated
  // bit by bit, so it is ready for the cycle after the last data bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= even_parity(32'(load_data));
    end
  end
`endif

endmodule
